md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multiply/divide unit: next generation of the datapath arithmetic block.
- Adds multi-cycle MULT/MULTU/DIV/DIVU, HI/LO result registers, a start/busy handshake and MTHI/MTLO writes.
- Sits in the EX stage beside the combinational ALU.
- The pipeline controller stalls any MD instruction, or HI/LO read, while busy=1.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).
- CNT_W, 8, latency counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a clk edge
- op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6/7=no-op
- a  input  WIDTH  operand A (rs); latched on accept
- b  input  WIDTH  operand B (rt); latched on accept
- busy  output  1  operation in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- div_zero  output  1  sticky: last accepted divide had b==0

Behaviour:
- Reset (async, immediate): busy=0, hi=0, lo=0, div_zero=0, counter=0, latched operands=0. Reset mid-operation aborts the operation; no commit follows.
- Accept: start=1 and busy=0 on a clk edge. start while busy=1 is ignored entirely, including MTHI/MTLO; no queueing.
- MTHI/MTLO: single cycle, busy stays 0. At the accepting edge: hi<=a (MTHI) or lo<=a (MTLO); the other register is unchanged.
- Op 6/7: accepted, no effect.
- MULT/MULTU/DIV/DIVU, accepted at edge E0:
  - Latch a, b, op.
  - busy=1 from E0 through edge E0+N, where N = MULT_CYCLES or DIV_CYCLES. busy is high for exactly N cycles.
  - At E0+N: busy<=0, and hi/lo update at the same edge. New values are visible in the first cycle with busy=0.
  - A new start is accepted at E0+N+1 at the earliest; no back-to-back overlap.
- Two-state FSM: IDLE -> RUN on accept of op 0-3. RUN counts the counter down from N-1. RUN -> IDLE at count 0 with commit.
- MULT: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- MULTU: unsigned 2*WIDTH product; same split as MULT.
- DIV: signed. Quotient truncates toward zero into lo; remainder into hi. The remainder takes the sign of the dividend.
- DIV special case: a = most-negative, b = -1 gives lo = most-negative, hi = 0. No trap.
- DIVU: unsigned; lo = quotient, hi = remainder.
- b==0 on a divide:
  - busy still runs DIV_CYCLES.
  - hi/lo are unchanged at commit.
  - div_zero<=1 at the accepting edge.
- div_zero is cleared by the next accepted divide with b!=0, or by reset.
- Operand changes on a/b during RUN have no effect; the latched copies are used.
- Implementation of the arithmetic (combinational on latched operands, or iterative) is free, provided the latency and commit timing above hold exactly.

Decomposition:
- Shared package md_pkg:
  - Op encodings MD_MULT..MD_MTLO and MD_NOP.
  - FSM state typedef (IDLE, RUN).
  - Default latency constants.
- One sub-module, md_latency_ctr:
  - Loadable down-counter (load value, enable, zero flag).
  - Owns the busy timing; the parent holds operand latches, arithmetic and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFE b=0x00000003 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI a=0x1234 (hi=0x1234), then DIVU a=7 b=0 -> busy 10 cycles, div_zero=1, hi=0x1234 and lo unchanged afterwards.
- MULT started, then start MTLO a=0x55 and a second MULT at cycle 2 of busy -> both ignored; lo = first product only.
- Reset asserted at cycle 3 of a DIV -> busy, hi, lo, div_zero go to 0 immediately; no commit after reset release.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states and
// default latencies.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;
    localparam logic [2:0] MD_NOP   = 3'd6;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

    typedef enum logic {
        StIdle,
        StRun
    } md_state_e;

endpackage

// File: rtl/md_latency_ctr.sv
// Loadable down-counter that times a multi-cycle MD operation; zero marks the
// commit cycle.
module md_latency_ctr #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers and a start/busy
// handshake; MTHI/MTLO write HI/LO in a single cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic             accept, accept_md, cnt_zero, commit;
    logic [CNT_W-1:0] load_val;

    assign accept    = start && (state_q == StIdle);
    assign accept_md = accept && (op[2] == 1'b0);
    assign commit    = (state_q == StRun) && cnt_zero;
    assign load_val  = op[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);

    md_latency_ctr #(
        .CNT_W (CNT_W)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept_md),
        .load_val (load_val),
        .en       (state_q == StRun),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept_md) state_d = StRun;
            StRun:   if (cnt_zero) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Arithmetic on the latched operands; only sampled in the commit cycle.
    logic [2*WIDTH-1:0]      prod_s, prod_u;
    logic signed [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH-1:0]        quo_u, rem_u;
    logic                    div_ovf;

    assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign div_ovf = (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        quo_u = a_q / b_q;
        rem_u = a_q % b_q;
        if (div_ovf) begin
            quo_s = $signed(a_q);
            rem_s = '0;
        end else begin
            quo_s = $signed(a_q) / $signed(b_q);
            rem_s = $signed(a_q) % $signed(b_q);
        end
    end

    always_comb begin
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;
        if (accept) begin
            if (op == MD_MTHI) hi_d = a;
            if (op == MD_MTLO) lo_d = a;
            if (op == MD_DIV || op == MD_DIVU) div_zero_d = (b == '0);
        end else if (commit) begin
            unique case (op_q)
                MD_MULT:  {hi_d, lo_d} = prod_s;
                MD_MULTU: {hi_d, lo_d} = prod_u;
                MD_DIV:   if (b_q != '0) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end
                MD_DIVU:  if (b_q != '0) begin
                    hi_d = rem_u;
                    lo_d = quo_u;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
            if (accept_md) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op;
            end
        end
    end

    assign busy     = (state_q == StRun);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed vector table, randomized ops against a 64-bit
// arithmetic reference model, and hand-written busy/reset corner sequences.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd6;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic [31:0] hi, lo;
    logic        div_zero;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    md_unit #(
        .WIDTH       (32),
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int exp_cycles(input logic [2:0] o);
        if (o <= 3'd1) return 5;
        if (o <= 3'd3) return 10;
        return 0;
    endfunction

    // Reference: results from 64-bit integer arithmetic.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin
                p = 64'(sx * sy);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd1: begin
                p = {32'b0, x} * {32'b0, y};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                m_dz = (y == 0);
                if (y != 0) begin
                    q = sx / sy;
                    r = sx % sy;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
            3'd3: begin
                m_dz = (y == 0);
                if (y != 0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            3'd4: m_hi = x;
            3'd5: m_lo = x;
            default: ;
        endcase
    endtask

    // Issues one accepted op and returns how many cycles busy stayed high.
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int cyc);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~x;
        b = ~y;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [31:0] hi, lo;
        logic        dz;
        int          cyc;
    } vec_t;

    vec_t vecs[9];
    int   cyc;

    initial begin
        vecs[0] = '{3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 5};
        vecs[1] = '{3'd1, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 1'b0, 5};
        vecs[2] = '{3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 10};
        vecs[3] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 10};
        vecs[4] = '{3'd4, 32'h1234, 32'h0, 32'h1234, 32'h80000000, 1'b0, 0};
        vecs[5] = '{3'd3, 32'h7, 32'h0, 32'h1234, 32'h80000000, 1'b1, 10};
        vecs[6] = '{3'd5, 32'h55, 32'h9, 32'h1234, 32'h55, 1'b1, 0};
        vecs[7] = '{3'd6, 32'hDEAD, 32'hBEEF, 32'h1234, 32'h55, 1'b1, 0};
        vecs[8] = '{3'd3, 32'h7, 32'h2, 32'h1, 32'h3, 1'b0, 10};

        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            model_apply(vecs[i].op, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            chk($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            chk($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            chk($sformatf("vec%0d_dz", i), 32'(div_zero), 32'(vecs[i].dz));
        end

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'h0;
            if (sel == 1) rb = 32'hFFFFFFFF;
            if (sel == 2) ra = 32'h80000000;
            if (sel == 3) rb = 32'($urandom_range(1, 16));
            run_op(ro, ra, rb, cyc);
            model_apply(ro, ra, rb);
            chk($sformatf("rnd%0d_op%0d_cycles", i, ro), 32'(cyc), 32'(exp_cycles(ro)));
            chk($sformatf("rnd%0d_op%0d_hi", i, ro), hi, m_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, ro), lo, m_lo);
            chk($sformatf("rnd%0d_op%0d_dz", i, ro), 32'(div_zero), 32'(m_dz));
        end

        // Starts presented while busy must be dropped, MTLO included.
        @(negedge clk);
        start = 1'b1;
        op = 3'd0;
        a = 32'h00012345;
        b = 32'hFFFFFF00;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_apply(3'd0, 32'h00012345, 32'hFFFFFF00);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            if (cyc == 2) begin
                start = 1'b1;
                op = 3'd5;
                a = 32'h55;
            end
            if (cyc == 3) begin
                op = 3'd0;
                a = 32'h7;
                b = 32'h9;
            end
            if (cyc == 4) start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("ignore_cycles", 32'(cyc), 32'd5);
        chk("ignore_hi", hi, m_hi);
        chk("ignore_lo", lo, m_lo);
        @(posedge clk);
        #1;
        chk("ignore_no_queue", 32'(busy), 32'd0);

        // Reset in the middle of a divide aborts it with no later commit.
        run_op(3'd3, 32'h0, 32'h0, cyc);
        model_apply(3'd3, 32'h0, 32'h0);
        chk("pre_dz", 32'(div_zero), 32'd1);
        @(negedge clk);
        start = 1'b1;
        op = 3'd2;
        a = 32'h100;
        b = 32'h7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        chk("rst_mid_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_after_busy", 32'(busy), 32'd0);
        chk("rst_after_hi", hi, 32'd0);
        chk("rst_after_lo", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
